// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type bits, port direction codes, per-VC states and XY routing.
// Purely combinational helpers; no latency, no flow control.
package noc_pkg;

  localparam int FT_HOF = 0;
  localparam int FT_BOF = 1;
  localparam int FT_EOF = 2;

  localparam logic [2:0] DIR_S = 3'd0;
  localparam logic [2:0] DIR_W = 3'd1;
  localparam logic [2:0] DIR_N = 3'd2;
  localparam logic [2:0] DIR_E = 3'd3;
  localparam logic [2:0] DIR_L = 3'd4;

  typedef enum logic [1:0] {
    VC_IDLE,
    VC_ROUTE,
    VC_VCREQ,
    VC_ACTIVE
  } vc_state_t;

  // X is resolved before Y; an exact address match ejects locally.
  function automatic logic [2:0] xy_route(input logic [7:0] dx, input logic [7:0] dy,
                                          input logic [7:0] ax, input logic [7:0] ay);
    if (dx > ax)      return DIR_E;
    else if (dx < ax) return DIR_W;
    else if (dy > ay) return DIR_N;
    else if (dy < ay) return DIR_S;
    else              return DIR_L;
  endfunction

endpackage

// File: rtl/sync_vc_inpbuf_if.sv
// Upstream link and allocator-facing signals of one router input port.
// master = router/upstream side, slave = input buffer.
interface sync_vc_inpbuf_if #(
  parameter int DW  = 32,
  parameter int VCN = 2,
  parameter int SN  = 5,
  parameter int FT  = 3
);
  logic                     div;
  logic [DW-1:0]            di;
  logic [FT-1:0]            dit;
  logic [VCN-1:0]           divc;
  logic [VCN-1:0]           cr;
  logic [VCN-1:0][SN-1:0]   vcr;
  logic [VCN-1:0]           vcra;
  logic [VCN-1:0]           swr;
  logic [VCN-1:0]           swa;
  logic [VCN-1:0][DW-1:0]   dout;
  logic [VCN-1:0][FT-1:0]   dot;
  logic [VCN-1:0][SN-1:0]   dortg;

  modport master (
    output div, di, dit, divc, vcra, swa,
    input  cr, vcr, swr, dout, dot, dortg
  );

  modport slave (
    input  div, di, dit, divc, vcra, swa,
    output cr, vcr, swr, dout, dot, dortg
  );

endinterface

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO with wrap-bit pointers; head visible combinationally the cycle after push.
// Caller must not push when full unless popping in the same cycle (pop frees the slot first).
module vc_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdat,
  output logic [W-1:0] o_rdat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdat  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdat;
  end

endmodule

// File: rtl/sync_vc_inpbuf.sv
// Router input port: per-VC FIFO, XY route, VC/switch requests, one-cycle credit per pop; head-to-swr >= 3 cycles.
// Writes are credit-governed (full-FIFO pushes dropped); SYNC_INPBUF_ERRCHK_EN enables the sticky err checker.
module sync_vc_inpbuf
  import noc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int VCN   = 2,
  parameter int DEPTH = 4,
  parameter int DIR   = 0,
  parameter int SN    = 5,
  parameter int FT    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         addrx,
  input  logic [7:0]         addry,
  sync_vc_inpbuf_if.slave    bif,
  output logic               err
);

  localparam int FW = DW + FT;

  vc_state_t              r_state  [VCN];
  vc_state_t              w_nstate [VCN];
  logic [VCN-1:0]         w_push;
  logic [VCN-1:0]         w_wr;
  logic [VCN-1:0]         w_pop;
  logic [VCN-1:0]         w_full;
  logic [VCN-1:0]         w_empty;
  logic [VCN-1:0]         w_hd_hof;
  logic [VCN-1:0]         w_hd_eof;
  logic [VCN-1:0]         w_swr;
  logic [VCN-1:0]         r_cr;
  logic [VCN-1:0][FW-1:0] w_rdat;
  logic [VCN-1:0][2:0]    w_route;
  logic [VCN-1:0][SN-1:0] w_vcr;
  logic [VCN-1:0][SN-1:0] r_rtg;

  for (genvar v = 0; v < VCN; v++) begin : g_vc
    assign w_push[v] = bif.div & bif.divc[v];
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign w_wr[v]   = w_push[v] & (~w_full[v] | w_pop[v]);

    vc_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_wr[v]),
      .i_pop   (w_pop[v]),
      .i_wdat  ({bif.dit, bif.di}),
      .o_rdat  (w_rdat[v]),
      .o_full  (w_full[v]),
      .o_empty (w_empty[v])
    );

    assign bif.dout[v] = w_rdat[v][DW-1:0];
    assign bif.dot[v]  = w_rdat[v][FW-1:DW];
    assign w_hd_hof[v] = w_rdat[v][DW+FT_HOF];
    assign w_hd_eof[v] = w_rdat[v][DW+FT_EOF];
    assign w_route[v]  = xy_route(w_rdat[v][7:0], w_rdat[v][15:8], addrx, addry);
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VCN; v++) begin
      if (rst) r_state[v] <= VC_IDLE;
      else     r_state[v] <= w_nstate[v];
    end
  end

  always_comb begin
    for (int v = 0; v < VCN; v++) begin
      w_nstate[v] = r_state[v];
      case (r_state[v])
        VC_IDLE:   if (!w_empty[v] && w_hd_hof[v]) w_nstate[v] = VC_ROUTE;
        VC_ROUTE:  w_nstate[v] = VC_VCREQ;
        VC_VCREQ:  if (bif.vcra[v]) w_nstate[v] = VC_ACTIVE;
        VC_ACTIVE: if (w_pop[v] && w_hd_eof[v]) w_nstate[v] = VC_IDLE;
        default:   w_nstate[v] = VC_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int v = 0; v < VCN; v++) begin
      w_vcr[v] = '0;
      w_swr[v] = 1'b0;
      case (r_state[v])
        VC_VCREQ:  w_vcr[v] = r_rtg[v];
        VC_ACTIVE: w_swr[v] = ~w_empty[v];
        default:   ;
      endcase
    end
  end

  assign w_pop = w_swr & bif.swa;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rtg <= '0;
      r_cr  <= '0;
    end else begin
      r_cr <= w_pop;
      for (int v = 0; v < VCN; v++) begin
        if (r_state[v] == VC_ROUTE)       r_rtg[v] <= SN'(1) << w_route[v];
        else if (w_pop[v] && w_hd_eof[v]) r_rtg[v] <= '0;
      end
    end
  end

  assign bif.cr    = r_cr;
  assign bif.vcr   = w_vcr;
  assign bif.swr   = w_swr;
  assign bif.dortg = r_rtg;

`ifdef SYNC_INPBUF_ERRCHK_EN
  logic [VCN-1:0] r_last_eof;
  logic [VCN-1:0] w_err_vc;
  logic           w_divc_bad;
  logic           r_err;

  assign w_divc_bad = bif.div &&
                      ((bif.divc == '0) || ((bif.divc & (bif.divc - VCN'(1))) != '0));

  always_comb begin
    for (int v = 0; v < VCN; v++) begin
      w_err_vc[v] = 1'b0;
      if (w_push[v] && w_full[v] && !w_pop[v])                        w_err_vc[v] = 1'b1;
      if (r_state[v] == VC_IDLE && !w_empty[v] && !w_hd_hof[v])       w_err_vc[v] = 1'b1;
      if (w_push[v] && bif.dit[FT_HOF] && !r_last_eof[v])             w_err_vc[v] = 1'b1;
      if (DIR != 4 && r_state[v] == VC_ROUTE && w_route[v] == 3'(DIR)) w_err_vc[v] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_last_eof <= '1;
    end else begin
      r_err <= r_err | (|w_err_vc) | w_divc_bad;
      for (int v = 0; v < VCN; v++) begin
        if (w_push[v]) r_last_eof[v] <= bif.dit[FT_EOF];
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
